// File: rtl/dm_access.sv
// Data-memory access stage: lane-merged stores and extended loads on a word RAM.
// Misaligned or out-of-range accesses raise AdEL/AdES; RAM is swept to zero after reset.
module dm_access #(
    parameter int          ADDR_W = 12,
    parameter logic [31:0] BASE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic        req_sign,
    input  logic [3:0]  req_byteen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_exc,
    output logic [4:0]  rsp_exc_code,
    output logic        trc_we,
    output logic [31:0] trc_addr,
    output logic [31:0] trc_data
);

    typedef enum logic {CLEAR, RUN} state_e;

    localparam logic [32:0] LIMIT = 33'd4 << ADDR_W;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [31:0]       mem [2**ADDR_W];

    logic [31:0]       off, old, rep, merged, ext;
    logic [ADDR_W-1:0] idx, mem_idx;
    logic [31:0]       mem_wd;
    logic              mem_we;
    logic              b_byte, b_half, b_word, misal, oor, exc, acc;

    logic              rsp_valid_d, exc_d, twe_d;
    logic [31:0]       rdata_d, taddr_d, tdata_d;
    logic [4:0]        code_d;

    assign off    = req_addr - BASE;
    assign idx    = off[ADDR_W+1:2];
    assign old    = mem[idx];
    assign oor    = {1'b0, off} >= LIMIT;
    assign b_byte = req_byteen inside {4'b0001, 4'b0010, 4'b0100, 4'b1000};
    assign b_half = req_byteen inside {4'b0011, 4'b1100};
    assign b_word = req_byteen == 4'b1111;
    assign misal  = (b_word && req_addr[1:0] != 2'b00) || (b_half && req_addr[0]);
    assign exc    = !(b_byte || b_half || b_word) || misal || oor;

    assign req_ready = state_q == RUN;
    assign acc       = req_valid && req_ready && (req_byteen != 4'b0000);

    always_comb begin
        unique case (1'b1)
            b_byte:  rep = {4{req_wdata[7:0]}};
            b_half:  rep = {2{req_wdata[15:0]}};
            default: rep = req_wdata;
        endcase
        for (int i = 0; i < 4; i++) begin
            merged[8*i+:8] = req_byteen[i] ? rep[8*i+:8] : old[8*i+:8];
        end
    end

    // Lane is chosen by the byte enables; the address only matters for alignment.
    always_comb begin
        case (req_byteen)
            4'b0001: ext = {{24{req_sign & old[7]}},  old[7:0]};
            4'b0010: ext = {{24{req_sign & old[15]}}, old[15:8]};
            4'b0100: ext = {{24{req_sign & old[23]}}, old[23:16]};
            4'b1000: ext = {{24{req_sign & old[31]}}, old[31:24]};
            4'b0011: ext = {{16{req_sign & old[15]}}, old[15:0]};
            4'b1100: ext = {{16{req_sign & old[31]}}, old[31:16]};
            default: ext = old;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_we      = 1'b0;
        mem_idx     = idx;
        mem_wd      = merged;
        rsp_valid_d = 1'b0;
        rdata_d     = '0;
        exc_d       = 1'b0;
        code_d      = '0;
        twe_d       = 1'b0;
        taddr_d     = '0;
        tdata_d     = '0;
        unique case (state_q)
            CLEAR: begin
                mem_we  = 1'b1;
                mem_idx = cnt_q;
                mem_wd  = '0;
                cnt_d   = cnt_q + 1'b1;
                if (&cnt_q) state_d = RUN;
            end
            RUN: begin
                if (acc) begin
                    rsp_valid_d = 1'b1;
                    if (exc) begin
                        exc_d  = 1'b1;
                        code_d = req_store ? 5'd5 : 5'd4;
                    end else if (req_store) begin
                        mem_we  = 1'b1;
                        twe_d   = 1'b1;
                        taddr_d = {req_addr[31:2], 2'b00};
                        tdata_d = merged;
                    end else begin
                        rdata_d = ext;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= CLEAR;
            cnt_q        <= '0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_exc      <= 1'b0;
            rsp_exc_code <= '0;
            trc_we       <= 1'b0;
            trc_addr     <= '0;
            trc_data     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rsp_valid    <= rsp_valid_d;
            rsp_rdata    <= rdata_d;
            rsp_exc      <= exc_d;
            rsp_exc_code <= code_d;
            trc_we       <= twe_d;
            trc_addr     <= taddr_d;
            trc_data     <= tdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_idx] <= mem_wd;
    end

endmodule
